dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sequences and shares the single-port word-addressed data memory between two requesters.
- Port 0 is the CPU load/store path. Port 1 is the debug/loader port.
- Round-robin arbitration with a fixed 3-state FSM; one access in flight at a time.
- Drives the memory's mem_address / write_data / sig_mem_read / sig_mem_write and captures read_data.

Parameters:
- DEPTH, 256, number of 32-bit words in the memory; addresses >= DEPTH are rejected.
- AW, 32, requester/memory address width (word address).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  port 0 request; held with fields stable until m0_ack.
- m0_we  in  1  port 0: 1 = write, 0 = read.
- m0_addr  in  AW  port 0 word address.
- m0_wdata  in  32  port 0 write data.
- m0_ack  out  1  port 0 completion pulse, one cycle.
- m0_err  out  1  port 0 out-of-range flag, valid with m0_ack.
- m0_rdata  out  32  port 0 read data, valid with m0_ack, held until the next m0_ack.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same as port 0, for port 1.
- mem_address  out  AW  to memory.
- write_data  out  32  to memory.
- sig_mem_read  out  1  memory read strobe.
- sig_mem_write  out  1  memory write strobe.
- read_data  in  32  from memory, combinational once sig_mem_read and mem_address are stable.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=1 so port 0 wins the first tie.
  - All outputs 0: acks, errs, rdata, mem_address, write_data, strobes.
  - Reset mid-transaction aborts it: strobes drop immediately, no ack is issued, a pending write may or may not have reached memory.
- FSM states: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE:
  - If no req, stay in IDLE.
  - Else pick the winner: a single requester wins outright; if both request, grant the port != last_grant.
  - Latch sel, we, addr, wdata. Set last_grant=sel. Go to ACCESS.
- ACCESS (exactly 1 cycle):
  - If addr < DEPTH: mem_address=addr; sig_mem_read=~we, sig_mem_write=we; write_data=wdata when we=1.
  - If addr >= DEPTH: both strobes stay 0 and the err flag is latched.
  - Go to DONE.
- DONE (1 cycle):
  - Strobes return to 0. mem_address and write_data hold their values.
  - Pulse ack[sel]=1 for this cycle.
  - Read: rdata[sel]=read_data sampled at the ACCESS->DONE edge. Write or error: rdata[sel]=0.
  - err[sel]=1 if the address was out of range, else 0.
  - Go to IDLE.
- Latency and throughput:
  - Req seen in IDLE at cycle N -> strobe in cycle N+1 -> ack in cycle N+2.
  - Peak rate is one transaction per 3 cycles.
- Handshake:
  - A requester deasserts req, or presents a new request, on the edge where it samples ack=1.
  - req sampled high in IDLE always starts a new transaction, so a req held past ack repeats the access.
  - Req or field changes during ACCESS/DONE are ignored; the transaction completes with the latched values.
- Fairness: under continuous contention grants alternate 0,1,0,1. A single active requester is granted every transaction.
- The other port's ack, err and rdata are unaffected by a transaction.
- Address compare is unsigned on the full AW bits.

Test Plan:
- Reset, then m0 read addr 5 with mem[5]=0xDEADBEEF -> sig_mem_read=1 in cycle 1 only, m0_ack in cycle 2, m0_rdata=0xDEADBEEF, m0_err=0.
- m1 write addr 10 data 0x12345678, then m0 read addr 10 -> sig_mem_write=1 for exactly one cycle with mem_address=10; m0_rdata=0x12345678.
- m0_req and m1_req both held high for 4 transactions -> grant order 0,1,0,1; acks 3 cycles apart, alternating ports.
- m0 read addr 256 (DEPTH=256) -> no strobe ever asserted; m0_ack=1 with m0_err=1 and m0_rdata=0.
- Start an m1 write, then assert rst_n=0 during ACCESS -> sig_mem_write falls immediately, no m1_ack; after release, first tie between m0 and m1 is granted to m0.
- m0_addr changed from 3 to 7 during ACCESS -> mem_address stays 3 and m0_rdata=mem[3].

Source files
------------

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Two requesters share one single-port, word-addressed data memory.
//   Port 0 is the CPU load/store path and port 1 is the debug/loader port.
//   When both ports request at once, the grant alternates between them.
//   Only one access is in flight at a time, and every output is registered.
//
// Ports
//   i_clk, i_rst_n          rising-edge clock, async active-low reset
//   i_mN_req/we/addr/wdata  request from port N (held stable until o_mN_ack)
//   o_mN_ack                one-cycle completion pulse for port N
//   o_mN_err                address was out of range (valid with ack)
//   o_mN_rdata              read result (valid with ack, held until next ack)
//   o_mem_address           word address to the memory
//   o_write_data            write data to the memory
//   o_sig_mem_read          memory read strobe
//   o_sig_mem_write         memory write strobe
//   i_read_data             memory read data, combinational from address
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | waiting for a request; picks the winner and launches the access
// ACCESS | strobe is on the memory bus (or suppressed for a bad address)
// DONE   | ack pulse to the winner; read data / error flag presented
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DEPTH = 256,
    parameter int AW    = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,

    input  logic          i_m0_req,
    input  logic          i_m0_we,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [31:0]   i_m0_wdata,
    output logic          o_m0_ack,
    output logic          o_m0_err,
    output logic [31:0]   o_m0_rdata,

    input  logic          i_m1_req,
    input  logic          i_m1_we,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [31:0]   i_m1_wdata,
    output logic          o_m1_ack,
    output logic          o_m1_err,
    output logic [31:0]   o_m1_rdata,

    output logic [AW-1:0] o_mem_address,
    output logic [31:0]   o_write_data,
    output logic          o_sig_mem_read,
    output logic          o_sig_mem_write,
    input  logic [31:0]   i_read_data
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    logic [1:0]    r_state;
    logic          r_last_grant;
    logic          r_sel;
    logic          r_we;
    logic          r_oor;

    logic [AW-1:0] r_mem_address;
    logic [31:0]   r_write_data;
    logic          r_sig_mem_read;
    logic          r_sig_mem_write;

    logic          r_m0_ack;
    logic          r_m0_err;
    logic [31:0]   r_m0_rdata;
    logic          r_m1_ack;
    logic          r_m1_err;
    logic [31:0]   r_m1_rdata;

    logic          w_any_req;
    logic          w_sel;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [31:0]   w_wdata;
    logic          w_in_range;
    logic          w_launch;
    logic          w_finish;
    logic [31:0]   w_resp_rdata;

    // Winner selection. A lone requester always wins. On a tie, the port that
    // was not granted last time wins. Reset leaves last_grant at 1, so port 0
    // wins the first tie.
    always_comb begin
        w_sel = 1'b0;
        if (i_m0_req && i_m1_req) begin
            w_sel = ~r_last_grant;
        end else if (i_m1_req) begin
            w_sel = 1'b1;
        end
    end

    assign w_any_req  = i_m0_req | i_m1_req;
    assign w_we       = w_sel ? i_m1_we    : i_m0_we;
    assign w_addr     = w_sel ? i_m1_addr  : i_m0_addr;
    assign w_wdata    = w_sel ? i_m1_wdata : i_m0_wdata;
    assign w_in_range = (w_addr < DEPTH_A);

    assign w_launch = (r_state == S_IDLE) && w_any_req;
    assign w_finish = (r_state == S_ACCESS);

    // The response data is sampled on the ACCESS->DONE edge. The memory is
    // still being read through i_read_data at that point. Writes and rejected
    // addresses return zero.
    assign w_resp_rdata = (!r_we && !r_oor) ? i_read_data : 32'h0;

    // Control state. The winner's fields are captured directly into the
    // memory-side registers below, so only sel/we/oor are kept here.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_sel        <= 1'b0;
            r_we         <= 1'b0;
            r_oor        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_sel        <= w_sel;
                        r_we         <= w_we;
                        r_oor        <= ~w_in_range;
                        r_last_grant <= w_sel;
                        r_state      <= S_ACCESS;
                    end
                end
                S_ACCESS: r_state <= S_DONE;
                S_DONE:   r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Memory-side registers. The strobe is raised on the launch edge, so it is
    // visible for exactly the ACCESS cycle. The address and write data hold
    // afterwards. A bad address leaves the bus untouched.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem_address   <= '0;
            r_write_data    <= 32'h0;
            r_sig_mem_read  <= 1'b0;
            r_sig_mem_write <= 1'b0;
        end else begin
            r_sig_mem_read  <= 1'b0;
            r_sig_mem_write <= 1'b0;
            if (w_launch && w_in_range) begin
                r_mem_address   <= w_addr;
                r_sig_mem_read  <= ~w_we;
                r_sig_mem_write <= w_we;
                if (w_we) begin
                    r_write_data <= w_wdata;
                end
            end
        end
    end

    // Port 0 response. The ack is a single pulse.
    // err and rdata hold until the next ack on this port.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_m0_ack   <= 1'b0;
            r_m0_err   <= 1'b0;
            r_m0_rdata <= 32'h0;
        end else begin
            r_m0_ack <= 1'b0;
            if (w_finish && !r_sel) begin
                r_m0_ack   <= 1'b1;
                r_m0_err   <= r_oor;
                r_m0_rdata <= w_resp_rdata;
            end
        end
    end

    // Port 1 response, mirror of port 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_m1_ack   <= 1'b0;
            r_m1_err   <= 1'b0;
            r_m1_rdata <= 32'h0;
        end else begin
            r_m1_ack <= 1'b0;
            if (w_finish && r_sel) begin
                r_m1_ack   <= 1'b1;
                r_m1_err   <= r_oor;
                r_m1_rdata <= w_resp_rdata;
            end
        end
    end

    assign o_mem_address   = r_mem_address;
    assign o_write_data    = r_write_data;
    assign o_sig_mem_read  = r_sig_mem_read;
    assign o_sig_mem_write = r_sig_mem_write;

    assign o_m0_ack   = r_m0_ack;
    assign o_m0_err   = r_m0_err;
    assign o_m0_rdata = r_m0_rdata;
    assign o_m1_ack   = r_m1_ack;
    assign o_m1_err   = r_m1_err;
    assign o_m1_rdata = r_m1_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = 32'h0, m0_wdata = 32'h0;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = 32'h0, m1_wdata = 32'h0;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_address, write_data, read_data;
    logic        sig_mem_read, sig_mem_write;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic [31:0] last_rdata [2];
    logic        mem_init = 1'b0;
    int          strobe_total = 0;
    int          in_range_cnt = 0;
    int          tests_run = 0;
    int          fails = 0;

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t vecs [11];

    dmem_arbiter #(.DEPTH(256), .AW(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
        .o_m0_ack(m0_ack), .o_m0_err(m0_err), .o_m0_rdata(m0_rdata),
        .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
        .o_m1_ack(m1_ack), .o_m1_err(m1_err), .o_m1_rdata(m1_rdata),
        .o_mem_address(mem_address), .o_write_data(write_data),
        .o_sig_mem_read(sig_mem_read), .o_sig_mem_write(sig_mem_write),
        .i_read_data(read_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(int i);
        return (i == 5) ? 32'hDEADBEEF : 32'h1000_0000 + i;
    endfunction

    // Behavioural memory: combinational read and a write on the clock edge.
    assign read_data = sig_mem_read ? mem[mem_address[7:0]] : 32'hBAD0_BAD0;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] = init_val(i);
        end else if (sig_mem_write) begin
            mem[mem_address[7:0]] = write_data;
        end
    end

    always @(negedge clk) if (sig_mem_read || sig_mem_write) strobe_total++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] port_rdata(int p);
        return (p == 0) ? m0_rdata : m1_rdata;
    endfunction
    function automatic logic port_ack(int p);
        return (p == 0) ? m0_ack : m1_ack;
    endfunction
    function automatic logic port_err(int p);
        return (p == 0) ? m0_err : m1_err;
    endfunction

    task automatic drive(input int p, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    // Issue one request at the current negedge and wait for its ack. The wait
    // is bounded. The request is dropped on the negedge where the ack is seen.
    task automatic run_txn(input int p, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic err, output int lat, output int strobes,
                           output logic [31:0] saddr, output logic [31:0] swdata,
                           output logic ok);
        drive(p, 1'b1, we, addr, wdata);
        lat = 0; strobes = 0; ok = 1'b0; saddr = 32'h0; swdata = 32'h0;
        rdata = 32'h0; err = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            lat++;
            if (sig_mem_read || sig_mem_write) begin
                strobes++;
                saddr  = mem_address;
                swdata = write_data;
            end
            if (port_ack(p)) begin
                rdata = port_rdata(p);
                err   = port_err(p);
                ok    = 1'b1;
                break;
            end
        end
        drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        mem_init = 1'b1;
        @(negedge clk);
        mem_init = 1'b0;
        @(negedge clk);
        check("rst_ack_err", {28'h0, m0_ack, m1_ack, m0_err, m1_err}, 32'h0);
        check("rst_m0_rdata", m0_rdata, 32'h0);
        check("rst_m1_rdata", m1_rdata, 32'h0);
        check("rst_mem_address", mem_address, 32'h0);
        check("rst_write_data", write_data, 32'h0);
        check("rst_strobes", {30'h0, sig_mem_read, sig_mem_write}, 32'h0);
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        last_rdata[0] = 32'h0;
        last_rdata[1] = 32'h0;
        rst_n = 1'b1;
    endtask

    task automatic run_random(input int p, input int n);
        logic [31:0] addr, wdata, rd, sa, sw, exp;
        logic        we, err, ok;
        int          lat, st, gap;
        for (int k = 0; k < n; k++) begin
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       addr = $urandom_range(256, 400);
                1:       addr = 32'hFFFF_FF00 | $urandom_range(0, 255);
                default: addr = $urandom_range(0, 31);
            endcase
            wdata = $urandom;
            run_txn(p, we, addr, wdata, rd, err, lat, st, sa, sw, ok);
            check("rnd_ack_seen", 32'(ok), 32'd1);
            if (ok) begin
                check("rnd_single_ack", 32'(port_ack(1 - p)), 32'd0);
                check("rnd_other_rdata", port_rdata(1 - p), last_rdata[1 - p]);
                if (addr >= 32'd256) begin
                    exp = 32'h0;
                    check("rnd_err", 32'(err), 32'd1);
                end else begin
                    in_range_cnt++;
                    check("rnd_err", 32'(err), 32'd0);
                    if (we) begin
                        ref_mem[addr[7:0]] = wdata;
                        exp = 32'h0;
                    end else begin
                        exp = ref_mem[addr[7:0]];
                    end
                end
                check("rnd_rdata", rd, exp);
                last_rdata[p] = exp;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, sa, sw;
        logic        err, ok;
        int          lat, st, nack, first_p, s0;
        int          ack_p [4];
        int          ack_t [4];

        vecs[0]  = '{0, 1'b0, 32'd5,          32'h0,         32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1, 1'b1, 32'd10,         32'h12345678,  32'h0,        1'b0};
        vecs[2]  = '{0, 1'b0, 32'd10,         32'h0,         32'h12345678, 1'b0};
        vecs[3]  = '{0, 1'b0, 32'd256,        32'h0,         32'h0,        1'b1};
        vecs[4]  = '{1, 1'b0, 32'd255,        32'h0,         32'h100000FF, 1'b0};
        vecs[5]  = '{1, 1'b1, 32'd255,        32'hA5A55A5A,  32'h0,        1'b0};
        vecs[6]  = '{0, 1'b0, 32'd255,        32'h0,         32'hA5A55A5A, 1'b0};
        vecs[7]  = '{0, 1'b1, 32'd300,        32'hFFFFFFFF,  32'h0,        1'b1};
        vecs[8]  = '{1, 1'b0, 32'h80000005,   32'h0,         32'h0,        1'b1};
        vecs[9]  = '{1, 1'b0, 32'd0,          32'h0,         32'h10000000, 1'b0};
        vecs[10] = '{0, 1'b0, 32'd5,          32'h0,         32'hDEADBEEF, 1'b0};

        do_reset();

        // Table of single-port transactions.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    rd, err, lat, st, sa, sw, ok);
            check($sformatf("vec%0d_ack_seen", i), 32'(ok), 32'd1);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_strobes", i), 32'(st),
                  (vecs[i].addr < 32'd256) ? 32'd1 : 32'd0);
            if (vecs[i].addr < 32'd256) begin
                check($sformatf("vec%0d_strobe_addr", i), sa, vecs[i].addr);
                if (vecs[i].we) check($sformatf("vec%0d_strobe_wdata", i), sw, vecs[i].wdata);
            end
            check($sformatf("vec%0d_other_rdata", i),
                  port_rdata(1 - vecs[i].port), last_rdata[1 - vecs[i].port]);
            last_rdata[vecs[i].port] = vecs[i].exp_rdata;
        end

        // Continuous contention: the grants should alternate 0,1,0,1 and be
        // spaced 3 cycles apart.
        @(negedge clk);
        do_reset();
        drive(0, 1'b1, 1'b0, 32'd1, 32'h0);
        drive(1, 1'b1, 1'b0, 32'd2, 32'h0);
        for (int k = 0; k < 4; k++) begin ack_p[k] = -1; ack_t[k] = -1; end
        nack = 0;
        for (int c = 1; c <= 40 && nack < 4; c++) begin
            @(negedge clk);
            if (m0_ack && m1_ack) check("cont_dual_ack", 32'd1, 32'd0);
            if (m0_ack || m1_ack) begin
                ack_p[nack] = m0_ack ? 0 : 1;
                ack_t[nack] = c;
                check($sformatf("cont_rdata%0d", nack), port_rdata(ack_p[nack]),
                      (ack_p[nack] == 0) ? 32'h10000001 : 32'h10000002);
                nack++;
                if (nack == 4) begin
                    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
                    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
                end
            end
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("cont_ack_count", 32'(nack), 32'd4);
        check("cont_first_time", 32'(ack_t[0]), 32'd2);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("cont_port%0d", k), 32'(ack_p[k]), 32'(k % 2));
            if (k > 0) check($sformatf("cont_gap%0d", k), 32'(ack_t[k] - ack_t[k-1]), 32'd3);
        end
        nack = 0;
        repeat (4) begin
            @(negedge clk);
            if (m0_ack || m1_ack) nack++;
        end
        check("cont_no_extra_ack", 32'(nack), 32'd0);

        // Reset during the ACCESS cycle of an m1 write.
        do_reset();
        drive(1, 1'b1, 1'b1, 32'd20, 32'hCAFEF00D);
        @(negedge clk);
        check("rstmid_write_strobe", 32'(sig_mem_write), 32'd1);
        check("rstmid_address", mem_address, 32'd20);
        #1 rst_n = 1'b0;
        #1 check("rstmid_strobe_drop", 32'(sig_mem_write), 32'd0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        nack = 0;
        repeat (3) begin
            @(negedge clk);
            if (m1_ack) nack++;
        end
        check("rstmid_no_ack", 32'(nack), 32'd0);
        rst_n = 1'b1;
        drive(0, 1'b1, 1'b0, 32'd4, 32'h0);
        drive(1, 1'b1, 1'b0, 32'd6, 32'h0);
        first_p = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin first_p = m0_ack ? 0 : 1; break; end
        end
        check("rstmid_first_tie", 32'(first_p), 32'd0);
        check("rstmid_m0_rdata", m0_rdata, 32'h10000004);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m1_ack) begin ok = 1'b1; break; end
        end
        check("rstmid_m1_ack", 32'(ok), 32'd1);
        check("rstmid_m1_rdata", m1_rdata, 32'h10000006);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Address change during ACCESS is ignored.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'd3, 32'h0);
        @(negedge clk);
        check("chg_read_strobe", 32'(sig_mem_read), 32'd1);
        check("chg_address", mem_address, 32'd3);
        m0_addr = 32'd7;
        @(negedge clk);
        check("chg_ack", 32'(m0_ack), 32'd1);
        check("chg_rdata", m0_rdata, 32'h10000003);
        check("chg_address_hold", mem_address, 32'd3);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Randomised concurrent traffic checked against a transaction-level model.
        @(negedge clk);
        do_reset();
        s0 = strobe_total;
        in_range_cnt = 0;
        fork
            run_random(0, 60);
            run_random(1, 60);
        join
        check("rnd_strobe_total", 32'(strobe_total - s0), 32'(in_range_cnt));

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
